// File: rtl/uart_tx_serializer.sv
// UART transmitter: byte FIFO feeding an 8N1 serializer with a programmable baud divider.
// Define UART_TX_PARITY_EN to insert an even-parity bit after data bit 7 (8E1 frames).
module uart_tx_serializer #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          tx_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  input  logic                          ovf_clr
);

  localparam int          AW     = $clog2(FIFO_DEPTH);
  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [7:0]  r_shift;
  logic [2:0]  r_idx;
  logic        r_txd;
`ifdef UART_TX_PARITY_EN
  logic        r_parity;
`endif

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [7:0]  r_mem [FIFO_DEPTH];
  logic        r_overflow;

  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_bit_end;
  logic [7:0]  w_head;

  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_push    = wr_en && !w_full;
  assign w_bit_end = (r_cnt == 16'd0);
  // Pop from IDLE, or at the last stop-bit cycle so back-to-back frames have no gap.
  assign w_pop     = !w_empty &&
                     ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));
  assign w_head    = r_mem[r_rd_ptr[AW-1:0]];

  assign tx_ready  = !w_full;
  assign level     = r_wr_ptr - r_rd_ptr;
  assign busy      = (r_state != S_IDLE) || !w_empty;
  assign txd       = r_txd;
  assign overflow  = r_overflow;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (wr_en && w_full) r_overflow <= 1'b1;
      else if (ovf_clr)    r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_shift  <= '0;
      r_idx    <= '0;
      r_txd    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_txd <= 1'b1;
          if (w_pop) begin
            r_shift  <= w_head;
            r_cnt    <= DIV_M1;
            r_txd    <= 1'b0;
            r_state  <= S_START;
`ifdef UART_TX_PARITY_EN
            r_parity <= ^w_head;
`endif
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_cnt   <= DIV_M1;
            r_txd   <= r_shift[0];
            r_idx   <= '0;
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_cnt <= DIV_M1;
            if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_txd   <= r_parity;
              r_state <= S_PARITY;
`else
              r_txd   <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              r_shift <= r_shift >> 1;
              r_txd   <= r_shift[1];
              r_idx   <= r_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_cnt   <= DIV_M1;
            r_txd   <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
`endif
        S_STOP: begin
          if (w_bit_end) begin
            r_cnt <= DIV_M1;
            if (w_pop) begin
              r_shift  <= w_head;
              r_txd    <= 1'b0;
              r_state  <= S_START;
`ifdef UART_TX_PARITY_EN
              r_parity <= ^w_head;
`endif
            end else begin
              r_txd   <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        default: begin
          r_txd   <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: two instances (div 4/depth 4 and div 2/depth 8) against a
// cycle-indexed frame model; honours UART_TX_PARITY_EN for the frame layout.
module tb_uart_tx_serializer;

  localparam int DIV0 = 4;
  localparam int DEP0 = 4;
  localparam int DIV1 = 2;
  localparam int DEP1 = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [7:0] wr_data = 8'h00;

  logic       txd0, rdy0, busy0, ovf0;
  logic       txd1, rdy1, busy1, ovf1;
  logic [2:0] lvl0;
  logic [3:0] lvl1;

  uart_tx_serializer #(.CLK_DIV(DIV0), .FIFO_DEPTH(DEP0)) u_dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .tx_ready(rdy0), .txd(txd0), .busy(busy0), .level(lvl0),
    .overflow(ovf0), .ovf_clr(ovf_clr)
  );

  uart_tx_serializer #(.CLK_DIV(DIV1), .FIFO_DEPTH(DEP1)) u_dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .tx_ready(rdy1), .txd(txd1), .busy(busy1), .level(lvl1),
    .overflow(ovf1), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: FIFO as a ring of bytes, transmitter as "active frame + cycle offset t".
  logic [7:0]  mbuf [2][256];
  int          mhead [2];
  int          mcnt [2];
  bit          mact [2];
  int          mt [2];
  bit          movf [2];
  logic [10:0] mframe [2];

  function automatic int divk(input int k);
    return (k == 0) ? DIV0 : DIV1;
  endfunction

  function automatic int depk(input int k);
    return (k == 0) ? DEP0 : DEP1;
  endfunction

  function automatic logic [10:0] build(input logic [7:0] b);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
`ifdef UART_TX_PARITY_EN
    f[9]   = ^b;
`endif
    return f;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mhead[k] = 0; mcnt[k] = 0; mact[k] = 1'b0; mt[k] = 0; movf[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input logic we, input logic [7:0] d, input logic clr);
    int fl;
    bit full, ending, pop;
    fl     = NBITS * divk(k);
    full   = (mcnt[k] == depk(k));
    ending = mact[k] && (mt[k] == fl - 1);
    pop    = (!mact[k] || ending) && (mcnt[k] != 0);
    if (pop) begin
      mframe[k] = build(mbuf[k][mhead[k]]);
      mhead[k]  = (mhead[k] + 1) % 256;
      mcnt[k]   = mcnt[k] - 1;
      mact[k]   = 1'b1;
      mt[k]     = 0;
    end else if (ending) begin
      mact[k] = 1'b0;
      mt[k]   = 0;
    end else if (mact[k]) begin
      mt[k] = mt[k] + 1;
    end
    if (clr) movf[k] = 1'b0;
    if (we) begin
      if (full) movf[k] = 1'b1;
      else begin
        mbuf[k][(mhead[k] + mcnt[k]) % 256] = d;
        mcnt[k] = mcnt[k] + 1;
      end
    end
  endtask

  task automatic check_all();
    int etx;
    for (int k = 0; k < 2; k++) begin
      etx = mact[k] ? int'(mframe[k][mt[k] / divk(k)]) : 1;
      check_eq($sformatf("txd[%0d]", k), (k == 0) ? int'(txd0) : int'(txd1), etx);
      check_eq($sformatf("level[%0d]", k), (k == 0) ? int'(lvl0) : int'(lvl1), mcnt[k]);
      check_eq($sformatf("busy[%0d]", k), (k == 0) ? int'(busy0) : int'(busy1),
               int'(mact[k] || (mcnt[k] != 0)));
      check_eq($sformatf("tx_ready[%0d]", k), (k == 0) ? int'(rdy0) : int'(rdy1),
               int'(mcnt[k] < depk(k)));
      check_eq($sformatf("overflow[%0d]", k), (k == 0) ? int'(ovf0) : int'(ovf1), int'(movf[k]));
    end
  endtask

  // Called at a falling edge; drives inputs for one rising edge, then checks at the next fall.
  task automatic cycle(input logic we, input logic [7:0] d, input logic clr);
    wr_en = we; wr_data = d; ovf_clr = clr;
    @(posedge clk);
    model_step(0, we, d, clr);
    model_step(1, we, d, clr);
    @(negedge clk);
    check_all();
    wr_en = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0);
  endtask

  // Asynchronous reset mid-cycle: outputs must return to reset values before any edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    check_eq("txd0_async_reset", int'(txd0), 1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int rate;
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    rst = 1'b0;

    cycle(1'b1, 8'h55, 1'b0);
    idle(50);

    cycle(1'b1, 8'hA5, 1'b0);
    cycle(1'b1, 8'h3C, 1'b0);
    idle(90);

    for (int i = 0; i < 6; i++) cycle(1'b1, 8'($urandom), 1'b0);
    check_eq("ovf_after_6_writes", int'(ovf0), 1);
    cycle(1'b0, 8'h00, 1'b1);
    idle(220);

    for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom), 1'b0);
    cycle(1'b1, 8'($urandom), 1'b1);
    idle(220);

    cycle(1'b1, 8'hFF, 1'b0);
    idle(18);
    do_reset();
    cycle(1'b1, 8'h00, 1'b0);
    idle(50);

    cycle(1'b1, 8'h07, 1'b0);
    cycle(1'b1, 8'h03, 1'b0);
    idle(100);

    rate = 2;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) rate = int'($urandom_range(0, 7));
      if ($urandom_range(0, 599) == 0) do_reset();
      else cycle(($urandom_range(0, 7) < rate), 8'($urandom), ($urandom_range(0, 49) == 0));
    end
    idle(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
